// File: rtl/hazard_scoreboard_ctrl.sv
// Hazard controller for the 5-stage core: EX/MEM/WB destination scoreboard,
// decode-stage forwarding selects, load-use stall and redirect flush sequencing.
module hazard_scoreboard_ctrl #(
  parameter int REGISTER_SIZE = 5,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic [REGISTER_SIZE-1:0]     dec_rs1,
  input  logic                         dec_rs1_used,
  input  logic [REGISTER_SIZE-1:0]     dec_rs2,
  input  logic                         dec_rs2_used,
  input  logic [REGISTER_SIZE-1:0]     dec_rd,
  input  logic                         dec_rd_we,
  input  logic                         dec_is_load,
  input  logic                         ex_redirect,
  output logic                         f_to_d_enable_ff,
  output logic                         d_to_e_enable_ff,
  output logic                         d_to_e_bubble,
  output logic                         f_to_d_flush,
  output logic [1:0][1:0]              pipeline_forward_sel,
  output logic [STALL_CNT_W-1:0]       stall_count
);

  // state      | meaning
  // RUN        | normal issue, hazards resolved by forwarding
  // LOAD_STALL | one bubble inserted; load now in MEM, forward from DM
  // FLUSH      | second flush cycle after a redirect (fetch latency)
  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} state_t;

  localparam logic [1:0] SEL_RF     = 2'd0;
  localparam logic [1:0] SEL_MEM_DM = 2'd1;
  localparam logic [1:0] SEL_EX_ALU = 2'd2;
  localparam logic [1:0] SEL_MEM_ALU = 2'd3;

  state_t                   state;
  logic                     ex_v, ex_ld, mem_v, mem_ld, wb_v, wb_ld;
  logic [REGISTER_SIZE-1:0] ex_rd, mem_rd, wb_rd;

  logic [1:0][REGISTER_SIZE-1:0] rs;
  logic [1:0]                    rs_used;
  logic [1:0]                    ex_hit, mem_hit, wb_hit;
  logic                          load_use;
  logic                          stall_now;

  assign rs      = {dec_rs2, dec_rs1};
  assign rs_used = {dec_rs2_used, dec_rs1_used};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ex_hit[i]  = rs_used[i] && (rs[i] != '0) && ex_v  && (ex_rd  == rs[i]);
      mem_hit[i] = rs_used[i] && (rs[i] != '0) && mem_v && (mem_rd == rs[i]);
      wb_hit[i]  = rs_used[i] && (rs[i] != '0) && wb_v  && (wb_rd  == rs[i]);
    end
  end

  // Youngest producer wins; an EX load cannot forward yet and forces a stall.
  // WB hits read the write-through register file, so they also select RF.
  always_comb begin
    load_use             = 1'b0;
    pipeline_forward_sel = '0;
    for (int i = 0; i < 2; i++) begin
      if (ex_hit[i]) begin
        if (ex_ld) load_use = 1'b1;
        else       pipeline_forward_sel[i] = SEL_EX_ALU;
      end else if (mem_hit[i]) begin
        pipeline_forward_sel[i] = mem_ld ? SEL_MEM_DM : SEL_MEM_ALU;
      end else if (wb_hit[i] && wb_ld) begin
        pipeline_forward_sel[i] = SEL_RF;
      end
    end
  end

  assign stall_now = (state == RUN) && !ex_redirect && dec_valid && load_use;

  always_comb begin
    f_to_d_enable_ff = 1'b1;
    d_to_e_enable_ff = 1'b1;
    d_to_e_bubble    = 1'b0;
    f_to_d_flush     = 1'b0;
    if (state == FLUSH || ex_redirect) begin
      f_to_d_flush  = 1'b1;
      d_to_e_bubble = 1'b1;
    end else if (stall_now) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_bubble    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      stall_count <= '0;
      ex_v  <= 1'b0; ex_rd  <= '0; ex_ld  <= 1'b0;
      mem_v <= 1'b0; mem_rd <= '0; mem_ld <= 1'b0;
      wb_v  <= 1'b0; wb_rd  <= '0; wb_ld  <= 1'b0;
    end else begin
      wb_v  <= mem_v; wb_rd  <= mem_rd; wb_ld  <= mem_ld;
      mem_v <= ex_v;  mem_rd <= ex_rd;  mem_ld <= ex_ld;
      if (d_to_e_enable_ff && !d_to_e_bubble) begin
        ex_v  <= dec_valid && dec_rd_we && (dec_rd != '0);
        ex_rd <= dec_rd;
        ex_ld <= dec_is_load;
      end else begin
        ex_v  <= 1'b0;
        ex_rd <= '0;
        ex_ld <= 1'b0;
      end

      if (stall_now && (stall_count != {STALL_CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;

      case (state)
        RUN:        state <= ex_redirect ? FLUSH : (stall_now ? LOAD_STALL : RUN);
        LOAD_STALL: state <= ex_redirect ? FLUSH : RUN;
        FLUSH:      state <= ex_redirect ? FLUSH : RUN;
        default:    state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl; a second instance with a 2-bit
// stall counter exercises saturation under the same stimulus.
module tb_hazard_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic       dec_rs1_used = 1'b0, dec_rs2_used = 1'b0;
  logic       dec_rd_we = 1'b0, dec_is_load = 1'b0, ex_redirect = 1'b0;

  logic            f_en, d_en, bubble, flush;
  logic [1:0][1:0] sel;
  logic [15:0]     stall_count;
  logic            f_en_s, d_en_s, bubble_s, flush_s;
  logic [1:0][1:0] sel_s;
  logic [1:0]      stall_count_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
    .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_is_load(dec_is_load),
    .ex_redirect(ex_redirect),
    .f_to_d_enable_ff(f_en), .d_to_e_enable_ff(d_en),
    .d_to_e_bubble(bubble), .f_to_d_flush(flush),
    .pipeline_forward_sel(sel), .stall_count(stall_count)
  );

  hazard_scoreboard_ctrl #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
    .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_is_load(dec_is_load),
    .ex_redirect(ex_redirect),
    .f_to_d_enable_ff(f_en_s), .d_to_e_enable_ff(d_en_s),
    .d_to_e_bubble(bubble_s), .f_to_d_flush(flush_s),
    .pipeline_forward_sel(sel_s), .stall_count(stall_count_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Applies one decode slot at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic redir);
    @(negedge clk);
    dec_valid = v; dec_rs1 = r1; dec_rs1_used = u1; dec_rs2 = r2; dec_rs2_used = u2;
    dec_rd = rd; dec_rd_we = we; dec_is_load = ld; ex_redirect = redir;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset
    nop();
    nop();
    check("rst_f_en", int'(f_en), 1);
    check("rst_d_en", int'(d_en), 1);
    check("rst_bubble", int'(bubble), 0);
    check("rst_flush", int'(flush), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_cnt", int'(stall_count), 0);
    @(negedge clk);
    rst = 1'b1;

    // ADD x5 ; SUB x6,x5,x1 -> EX ALU forward on A
    drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    drive(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
    check("alu_sel_a", int'(sel[0]), 2);
    check("alu_sel_b", int'(sel[1]), 0);
    check("alu_no_stall", int'(f_en), 1);
    check("alu_no_bubble", int'(bubble), 0);
    check("alu_cnt", int'(stall_count), 0);

    // LW x7 ; ADD x8,x7,x7 -> one stall then DM forward on both operands
    drive(1, 5'd0, 1, 5'd0, 0, 5'd7, 1, 1, 0);
    check("lw_rs_x0_sel", int'(sel[0]), 0);
    drive(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0);
    check("lu_f_en", int'(f_en), 0);
    check("lu_bubble", int'(bubble), 1);
    check("lu_d_en", int'(d_en), 1);
    check("lu_sel", int'(sel), 0);
    drive(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0);
    check("ls_f_en", int'(f_en), 1);
    check("ls_bubble", int'(bubble), 0);
    check("ls_sel_a", int'(sel[0]), 1);
    check("ls_sel_b", int'(sel[1]), 1);
    check("ls_cnt", int'(stall_count), 1);

    // ADD x9 ; NOP ; OR x10,x0,x9 -> MEM ALU forward on B
    drive(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0);
    nop();
    drive(1, 5'd0, 1, 5'd9, 1, 5'd10, 1, 0, 0);
    check("mem_alu_sel_a", int'(sel[0]), 0);
    check("mem_alu_sel_b", int'(sel[1]), 3);

    // load into x0 then read x0 on both operands -> no forwarding, no stall
    drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
    drive(1, 5'd0, 1, 5'd0, 1, 5'd11, 0, 0, 0);
    check("x0_sel", int'(sel), 0);
    check("x0_f_en", int'(f_en), 1);
    check("x0_bubble", int'(bubble), 0);

    // redirect coincident with load-use: two flush cycles, no stall
    drive(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 1, 0);
    drive(1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 1);
    check("rd1_flush", int'(flush), 1);
    check("rd1_bubble", int'(bubble), 1);
    check("rd1_f_en", int'(f_en), 1);
    drive(1, 5'd0, 0, 5'd0, 0, 5'd14, 1, 0, 0);
    check("rd2_flush", int'(flush), 1);
    check("rd2_bubble", int'(bubble), 1);
    nop();
    check("rd3_flush", int'(flush), 0);
    check("rd3_bubble", int'(bubble), 0);
    check("rd_cnt", int'(stall_count), 1);

    // four more load-use stalls: 16-bit counter reaches 5, 2-bit one holds at 3
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 1, 0);
      drive(1, 5'd0, 0, 5'd13, 1, 5'd14, 1, 0, 0);
      check("sat_stall", int'(f_en), 0);
      drive(1, 5'd0, 0, 5'd13, 1, 5'd14, 1, 0, 0);
      check("sat_sel_b", int'(sel[1]), 1);
      check("sat_cnt16", int'(stall_count), i + 2);
      check("sat_cnt2", int'(stall_count_s), (i + 2 > 3) ? 3 : i + 2);
    end

    // reset while in LOAD_STALL
    drive(1, 5'd0, 0, 5'd0, 0, 5'd14, 1, 1, 0);
    drive(1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 0);
    check("pre_rst_stall", int'(f_en), 0);
    drive(1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_sel_a", int'(sel[0]), 0);
    check("post_rst_f_en", int'(f_en), 1);
    check("post_rst_bubble", int'(bubble), 0);
    check("post_rst_cnt", int'(stall_count), 0);
    drive(1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 0);
    check("post_rst_dep_sel", int'(sel[0]), 0);
    drive(1, 5'd15, 1, 5'd0, 0, 5'd16, 1, 0, 0);
    check("post_rst_fwd", int'(sel[0]), 2);

    nop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
